fpa_share_ctrl: RTL
===================

Name: fpa_share_ctrl

Overview:
- Sequencing controller that shares one combinational single-precision FP adder (the team's fpa unit) between two requesters.
- Arbitrates round-robin, registers operands and holds them on the adder inputs for ADD_LAT cycles, then captures the sum.
- Returns the sum to the winning requester over a valid/ready response channel.
- Subtraction is supported by flipping the sign of operand B before issue.

Parameters:
- ADD_LAT, 1, number of cycles operands are held on the adder before the result is captured (legal 1..15).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > ADD_LAT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  request valid; bit i belongs to requester i.
- req_ready  output  2  request accepted; one-hot or zero.
- req_a0  input  32  requester 0 operand A (IEEE-754 single).
- req_b0  input  32  requester 0 operand B.
- req_a1  input  32  requester 1 operand A.
- req_b1  input  32  requester 1 operand B.
- req_sub  input  2  bit i=1: requester i wants A-B.
- add_in1  output  32  to adder in1.
- add_in2  output  32  to adder in2.
- add_out  input  32  from adder out (combinational).
- resp_valid  output  2  result valid for requester i; one-hot or zero.
- resp_ready  input  2  requester i takes result.
- resp_data  output  32  captured sum.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=0, resp_valid=0, resp_data=0, add_in1=0, add_in2=0, busy=0; owner=0; last_grant=1, so requester 0 wins first contention. Reset mid-operation aborts the operation; no response is ever issued for it.
- States: IDLE, HOLD, RESP.
- IDLE:
  - Grant is combinational from req_valid and last_grant.
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester != last_grant is granted.
  - req_ready[grant]=1 only in IDLE, only when req_valid[grant]=1.
  - On the handshake edge: latch add_in1=A, add_in2=B (or {~B[31],B[30:0]} if req_sub[grant]); owner=grant; last_grant=grant; cnt=ADD_LAT-1; go to HOLD.
- HOLD:
  - add_in1/add_in2 are stable; req_ready=0.
  - Each cycle with cnt!=0: cnt decrements.
  - On the edge where cnt==0: resp_data=add_out; go to RESP.
- RESP:
  - resp_valid[owner]=1; resp_data is stable.
  - When resp_ready[owner]=1, on that edge resp_valid clears, add_in1/add_in2 clear to 0, and state goes to IDLE.
  - resp_ready on the non-owner bit is ignored.
- Latency: request accepted in cycle T; resp_valid first high in cycle T+ADD_LAT+1. The earliest next acceptance is the cycle after the response handshake, so peak throughput is one op per ADD_LAT+2 cycles.
- A req_valid deasserted before handshake is legal: no grant, no state change. A requester not granted simply keeps req_valid high; no request is lost or duplicated.
- busy=1 in HOLD and RESP.
- Arithmetic is entirely in the external adder. The controller only muxes, sign-flips bit 31 and registers; no width change.
- Simultaneous new req_valid while in HOLD/RESP: ignored until IDLE.

Test Plan:
- Bench adder model is IEEE single add.
- Single request: ADD_LAT=1; req 0 A=0x3F800000, B=0x40000000, sub=0, accepted cycle T -> resp_valid=2'b01 at T+2, resp_data=0x40400000. resp_ready held high -> IDLE at T+3.
- Subtract: req 1 A=0x40400000, B=0x3F800000, sub=1 -> add_in2=0xBF800000 during HOLD; resp_valid=2'b10; resp_data=0x40000000.
- Contention: both valid from reset -> req 0 granted first. Both held valid -> grants alternate 0,1,0,1 over four ops; req_ready never 2'b11.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_data held, busy=1, req_ready=0. resp_ready[non-owner]=1 has no effect. Owner ready -> single completion.
- Latency sweep: ADD_LAT=3 -> add_in1/add_in2 stable 3 cycles; resp_valid at T+4.
- Reset mid-HOLD: assert rst during HOLD -> all outputs 0 immediately. After release, no resp_valid for the aborted op; next request from requester 0 wins.

Source files
------------

// File: rtl/fpa_share_ctrl.sv
// Shares one combinational single-precision adder between two requesters:
// round-robin grant, operand hold for ADD_LAT cycles, valid/ready result return.
module fpa_share_ctrl #(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [1:0]  req_sub,
    output logic [31:0] add_in1,
    output logic [31:0] add_in2,
    input  logic [31:0] add_out,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Subtraction is an addition with operand B's sign bit inverted.
    function automatic logic [31:0] fp_negate_if(input logic [31:0] val, input logic neg);
        return {val[31] ^ neg, val[30:0]};
    endfunction

    function automatic logic [1:0] one_hot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             owner_r;
    logic             last_grant_r;
    logic [31:0]      add_in1_r;
    logic [31:0]      add_in2_r;
    logic [31:0]      resp_data_r;
    logic [1:0]       resp_valid_r;
    logic             busy_r;

    logic             grant_s;
    logic             accept_s;
    logic [1:0]       req_ready_s;
    logic [31:0]      op_a_s;
    logic [31:0]      op_b_s;

    // Round-robin grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Request acceptance is only possible in IDLE and only for a valid granted requester.
    always_comb begin
        accept_s    = 1'b0;
        req_ready_s = 2'b00;
        if ((state_r == ST_IDLE) && req_valid[grant_s]) begin
            accept_s    = 1'b1;
            req_ready_s = one_hot(grant_s);
        end else begin
            accept_s    = 1'b0;
            req_ready_s = 2'b00;
        end
    end

    // Operand selection for the granted requester, with optional B negation.
    always_comb begin
        op_a_s = 32'h0000_0000;
        op_b_s = 32'h0000_0000;
        if (grant_s) begin
            op_a_s = req_a1;
            op_b_s = fp_negate_if(req_b1, req_sub[1]);
        end else begin
            op_a_s = req_a0;
            op_b_s = fp_negate_if(req_b0, req_sub[0]);
        end
    end

    // Sequencer: issue operands, hold them ADD_LAT cycles, capture, then return the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            add_in1_r    <= 32'h0000_0000;
            add_in2_r    <= 32'h0000_0000;
            resp_data_r  <= 32'h0000_0000;
            resp_valid_r <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        add_in1_r    <= op_a_s;
                        add_in2_r    <= op_b_s;
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= CNT_LOAD;
                        busy_r       <= 1'b1;
                        state_r      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        resp_data_r  <= add_out;
                        resp_valid_r <= one_hot(owner_r);
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    // Only the owner's ready completes the transfer.
                    if (resp_ready[owner_r]) begin
                        resp_valid_r <= 2'b00;
                        add_in1_r    <= 32'h0000_0000;
                        add_in2_r    <= 32'h0000_0000;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 2'b00;
                    add_in1_r    <= 32'h0000_0000;
                    add_in2_r    <= 32'h0000_0000;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held so every output reads zero during reset.
    assign req_ready  = rst ? 2'b00 : req_ready_s;
    assign add_in1    = add_in1_r;
    assign add_in2    = add_in2_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_r;

endmodule
